aes_sub_bytes_serial: RTL and testbench

Byte-serial SubBytes stage for the area-optimised AES cipher core. It accepts a full 128-bit state with a valid/ready handshake. It then substitutes NumSbox bytes per cycle through instances of the combinational S-box (forward or inverse, per op_i) and presents the result with a valid/ready handshake. It sits between the AddRoundKey/state register and the ShiftRows stage, trading latency for fewer S-box instances.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_sbox_lut.sv | 16 +
 rtl/aes_sub_bytes_serial.sv | 109 ++++++++++
 tb/tb_aes_sub_bytes_serial.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types plus the GF(2^8) helpers behind the combinational S-box.
package aes_pkg;

   typedef enum logic {
      CIPH_FWD = 1'b0,
      CIPH_INV = 1'b1
   } ciph_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_bytes_state_e;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and conveniently maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] aff_fwd(input logic [7:0] x);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] aff_inv(input logic [7:0] x);
      return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
   endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// Combinational AES S-box, forward or inverse selected by op_i.
module aes_sbox_lut
   import aes_pkg::*;
(
   input  ciph_op_e   op_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   // Forward: inverse then affine; inverse: undo the affine then invert.
   always_comb begin
      if (op_i == CIPH_FWD) data_o = aff_fwd(gf_inv(data_i));
      else                  data_o = gf_inv(aff_inv(data_i));
   end

endmodule

// File: rtl/aes_sub_bytes_serial.sv
// Byte-serial SubBytes: NumSbox S-boxes substitute the 128-bit state over 16/NumSbox cycles.
// Define AES_SUB_BYTES_WIPE_EN to wipe the state after output and blank data_o outside DONE.
module aes_sub_bytes_serial
   import aes_pkg::*;
#(
   parameter int NumSbox = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic         op_i,
   input  logic [127:0] data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] data_o,
   output logic         busy_o
);

   localparam int NumSteps = 16 / NumSbox;
   localparam int CntW     = (NumSteps > 1) ? $clog2(NumSteps) : 1;

   if (!(NumSbox == 1 || NumSbox == 2 || NumSbox == 4 || NumSbox == 8 || NumSbox == 16))
   begin : gen_bad_num_sbox
      $error("aes_sub_bytes_serial: NumSbox must be 1, 2, 4, 8 or 16");
   end

   sub_bytes_state_e state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [127:0]     data_q, data_d;
   ciph_op_e         op_q, op_d;

   logic [7:0] sbox_in  [NumSbox];
   logic [7:0] sbox_out [NumSbox];

   // Each S-box sees one byte of the group selected by the step counter.
   for (genvar g = 0; g < NumSbox; g++) begin : gen_sbox
      assign sbox_in[g] = data_q[(int'(cnt_q) * NumSbox + g) * 8 +: 8];
      aes_sbox_lut u_sbox (
         .op_i   (op_q),
         .data_i (sbox_in[g]),
         .data_o (sbox_out[g])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      op_d    = op_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               data_d  = data_i;
               op_d    = ciph_op_e'(op_i);
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NumSbox; i++) begin
               data_d[(int'(cnt_q) * NumSbox + i) * 8 +: 8] = sbox_out[i];
            end
            if (cnt_q == CntW'(NumSteps - 1)) state_d = DONE;
            else                              cnt_d   = cnt_q + CntW'(1);
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
`ifdef AES_SUB_BYTES_WIPE_EN
               data_d  = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      // Clear wins over everything, including a same-cycle input handshake.
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         op_q    <= CIPH_FWD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         op_q    <= op_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q == RUN) || (state_q == DONE);
`ifdef AES_SUB_BYTES_WIPE_EN
   assign data_o      = out_valid_o ? data_q : '0;
`else
   assign data_o      = data_q;
`endif

endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// Bench for aes_sub_bytes_serial: NumSbox=4 and NumSbox=1 instances against a table-driven S-box model.
module tb_aes_sub_bytes_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic clr4, iv4, ir4, op4, ov4, or4, busy4;
   logic [127:0] d4In, d4Out;
   logic clr1, iv1, ir1, op1, ov1, or1, busy1;
   logic [127:0] d1In, d1Out;

   int tests = 0;
   int failures = 0;

   logic [7:0] fwdT [256];
   logic [7:0] invT [256];

   aes_sub_bytes_serial #(.NumSbox(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr4), .in_valid_i(iv4), .in_ready_o(ir4),
      .op_i(op4), .data_i(d4In), .out_valid_o(ov4), .out_ready_i(or4), .data_o(d4Out),
      .busy_o(busy4)
   );

   aes_sub_bytes_serial #(.NumSbox(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr1), .in_valid_i(iv1), .in_ready_o(ir1),
      .op_i(op1), .data_i(d1In), .out_valid_o(ov1), .out_ready_i(or1), .data_o(d1Out),
      .busy_o(busy1)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return r;
   endfunction

   // Forward table from brute-force inversion plus the bitwise affine rule; inverse table by reversal.
   task automatic buildTables();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                   ^ inv[(i + 7) % 8] ^ c[i];
         end
         fwdT[x] = s;
      end
      for (int x = 0; x < 256; x++) invT[fwdT[x]] = 8'(x);
   endtask

   function automatic logic [127:0] refSub(input logic [127:0] d, input logic op);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = op ? invT[d[8*k +: 8]] : fwdT[d[8*k +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Hands one block to the chosen instance and waits (bounded) for out_valid.
   task automatic applyStimulus(input int which, input logic [127:0] d, input logic op,
                                output logic [127:0] res, output int lat);
      int guard;
      guard = 0;
      while (((which == 4) ? !ir4 : !ir1) && guard < 40) begin
         @(posedge clk); #1; guard++;
      end
      if (which == 4) begin iv4 = 1'b1; d4In = d; op4 = op; end
      else            begin iv1 = 1'b1; d1In = d; op1 = op; end
      @(posedge clk); #1;
      if (which == 4) begin iv4 = 1'b0; op4 = ~op; d4In = rand128(); end
      else            begin iv1 = 1'b0; op1 = ~op; d1In = rand128(); end
      lat = 0;
      while (((which == 4) ? !ov4 : !ov1) && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      res = (which == 4) ? d4Out : d1Out;
   endtask

   task automatic drainOut(input int which);
      if (which == 4) or4 = 1'b1; else or1 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
      or1 = 1'b0;
   endtask

   initial begin
      logic [127:0] d, res, expd, mixed;
      logic op, stable, rdyLow, sawValid;
      int lat;

      rst_n = 1'b0;
      {clr4, iv4, op4, or4, clr1, iv1, op1, or1} = '0;
      d4In = '0;
      d1In = '0;
      buildTables();

      #12;
      checkOutput("rst_in_ready4",  128'(ir4),   128'(1));
      checkOutput("rst_out_valid4", 128'(ov4),   128'(0));
      checkOutput("rst_busy4",      128'(busy4), 128'(0));
      checkOutput("rst_data4",      d4Out,       128'(0));
      checkOutput("rst_in_ready1",  128'(ir1),   128'(1));
      checkOutput("rst_data1",      d1Out,       128'(0));
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(4, 128'(0), 1'b0, res, lat);
      checkOutput("fwd_zero_lat",  128'(lat), 128'(4));
      checkOutput("fwd_zero_data", res, {16{8'h63}});
      checkOutput("fwd_zero_busy", 128'(busy4), 128'(1));
      drainOut(4);
      checkOutput("fwd_zero_idle_ready", 128'(ir4), 128'(1));

      mixed = {96'h0, 8'h53, 8'h02, 8'h01, 8'h00};
      applyStimulus(4, mixed, 1'b0, res, lat);
      checkOutput("fwd_mixed_const", res, {{12{8'h63}}, 8'hED, 8'h77, 8'h7C, 8'h63});
      checkOutput("fwd_mixed_model", res, refSub(mixed, 1'b0));
      drainOut(4);
`ifdef AES_SUB_BYTES_WIPE_EN
      checkOutput("idle_data_after_block", d4Out, 128'(0));
`else
      checkOutput("idle_data_after_block", d4Out, {{12{8'h63}}, 8'hED, 8'h77, 8'h7C, 8'h63});
`endif

      // Inverse on the single-S-box instance, watching in_ready through the whole run.
      iv1 = 1'b1; d1In = {16{8'h63}}; op1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0; op1 = 1'b0;
      lat = 0;
      rdyLow = 1'b1;
      while (!ov1 && lat < 40) begin
         if (ir1) rdyLow = 1'b0;
         @(posedge clk); #1; lat++;
      end
      checkOutput("inv_one_lat",       128'(lat), 128'(16));
      checkOutput("inv_one_data",      d1Out, 128'(0));
      checkOutput("inv_one_ready_low", 128'(rdyLow && !ir1), 128'(1));
      drainOut(1);

      // Backpressure: hold DONE for 10 cycles, then release and immediately send another block.
      d = rand128();
      op = 1'($urandom_range(0, 1));
      applyStimulus(4, d, op, res, lat);
      expd = refSub(d, op);
      checkOutput("bp_data", res, expd);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!(ov4 === 1'b1 && d4Out === expd && ir4 === 1'b0)) stable = 1'b0;
      end
      checkOutput("bp_stable", 128'(stable), 128'(1));
      drainOut(4);
      checkOutput("bp_release_ready", 128'(ir4), 128'(1));
      checkOutput("bp_release_valid", 128'(ov4), 128'(0));
      d = rand128();
      op = 1'($urandom_range(0, 1));
      expd = refSub(d, op);
      iv4 = 1'b1; d4In = d; op4 = op;
      @(posedge clk); #1;
      iv4 = 1'b0; op4 = ~op;
      checkOutput("bp_second_accepted", 128'({ir4, busy4}), 128'(2'b01));
`ifdef AES_SUB_BYTES_WIPE_EN
      checkOutput("run_data_step0", d4Out, 128'(0));
      @(posedge clk); #1;
      checkOutput("run_data_step1", d4Out, 128'(0));
`else
      checkOutput("run_data_step0", d4Out, d);
      @(posedge clk); #1;
      checkOutput("run_data_step1", d4Out, {d[127:32], expd[31:0]});
`endif
      lat = 0;
      while (!ov4 && lat < 40) begin @(posedge clk); #1; lat++; end
      checkOutput("bp_second_lat",  128'(lat), 128'(3));
      checkOutput("bp_second_data", d4Out, expd);
      drainOut(4);

      // Clear at the second RUN edge aborts the block.
      iv4 = 1'b1; d4In = rand128(); op4 = 1'b0;
      @(posedge clk); #1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      clr4 = 1'b1;
      @(posedge clk); #1;
      clr4 = 1'b0;
      checkOutput("clr_state", 128'({ir4, ov4, busy4}), 128'(3'b100));
      checkOutput("clr_data",  d4Out, 128'(0));
      sawValid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ov4) sawValid = 1'b1;
      end
      checkOutput("clr_no_output", 128'(sawValid), 128'(0));
      applyStimulus(4, 128'(0), 1'b0, res, lat);
      checkOutput("clr_after_data", res, {16{8'h63}});
      drainOut(4);

      // Clear together with an input handshake discards the input.
      iv4 = 1'b1; clr4 = 1'b1; d4In = rand128();
      @(posedge clk); #1;
      iv4 = 1'b0; clr4 = 1'b0;
      checkOutput("clr_hs_idle", 128'({ir4, busy4}), 128'(2'b10));

      for (int n = 0; n < 12; n++) begin
         d = rand128();
         op = 1'($urandom_range(0, 1));
         applyStimulus(4, d, op, res, lat);
         checkOutput("rand4_lat",  128'(lat), 128'(4));
         checkOutput("rand4_data", res, refSub(d, op));
         drainOut(4);
      end
      for (int n = 0; n < 3; n++) begin
         d = rand128();
         op = 1'($urandom_range(0, 1));
         applyStimulus(1, d, op, res, lat);
         checkOutput("rand1_lat",  128'(lat), 128'(16));
         checkOutput("rand1_data", res, refSub(d, op));
         drainOut(1);
      end

      // Asynchronous reset while an output is pending.
      applyStimulus(4, rand128(), 1'b0, res, lat);
      checkOutput("pre_rst_valid", 128'(ov4), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_state", 128'({ir4, ov4, busy4}), 128'(3'b100));
      checkOutput("async_rst_data",  d4Out, 128'(0));
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(4, {16{8'h63}}, 1'b1, res, lat);
      checkOutput("post_rst_inv", res, 128'(0));
      drainOut(4);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
